// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: controller for the single RW port of a 512x8 OpenRAM macro.
// After reset it writes INIT_VALUE to every address, then arbitrates two
// valid/ready requesters round-robin. Macro pins are registered. Read data comes
// back on a per-requester response channel two edges after the accept.
module sram_port_arbiter #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 9,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk0,
    input  logic                  rstb0,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    // Highest macro address (RAM_DEPTH-1), i.e. all address bits set.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    sweep_end_q, sweep_end_d;  // last init write is on the pins
    logic                    done_d;
    logic                    rr_ptr_q, rr_ptr_d;        // 0 favours requester 0
    logic                    csb_d, web_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   din_d;

    // Read pipeline: stage 1 tracks the command on the pins, stage 2 the
    // cycle in which the macro drives dout.
    logic                    rd_push_d;
    logic                    rd_id_d;
    logic                    rd_v1_q, rd_id1_q;
    logic                    rd_v2_q, rd_id2_q;

    // State, init counter, pointer and registered macro pins.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            sweep_end_q <= 1'b0;
            init_done   <= 1'b0;
            rr_ptr_q    <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            sweep_end_q <= sweep_end_d;
            init_done   <= done_d;
            rr_ptr_q    <= rr_ptr_d;
            sram_csb0   <= csb_d;
            sram_web0   <= web_d;
            sram_addr0  <= addr_d;
            sram_din0   <= din_d;
        end
    end

    // Next state, init sweep sequencing, arbitration and next pin values.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        sweep_end_d = sweep_end_q;
        done_d      = init_done;
        rr_ptr_d    = rr_ptr_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr_d      = sram_addr0;
        din_d       = sram_din0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rd_push_d   = 1'b0;
        rd_id_d     = rd_id1_q;

        unique case (state_q)
            ST_INIT: begin
                if (sweep_end_q) begin
                    // Final write already issued: release the pins and go live.
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    csb_d  = 1'b0;
                    web_d  = 1'b0;
                    addr_d = init_cnt_q;
                    din_d  = INIT_VALUE;
                    // Counter saturates at the last address; no second sweep.
                    if (init_cnt_q == LAST_ADDR) begin
                        sweep_end_d = 1'b1;
                    end else begin
                        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_RUN: begin
                req0_ready = req0_valid && (!req1_valid || !rr_ptr_q);
                req1_ready = req1_valid && (!req0_valid ||  rr_ptr_q);
                if (req0_ready) begin
                    csb_d     = 1'b0;
                    web_d     = ~req0_we;
                    addr_d    = req0_addr;
                    din_d     = req0_wdata;
                    rr_ptr_d  = 1'b1;
                    rd_push_d = ~req0_we;
                    rd_id_d   = 1'b0;
                end else if (req1_ready) begin
                    csb_d     = 1'b0;
                    web_d     = ~req1_we;
                    addr_d    = req1_addr;
                    din_d     = req1_wdata;
                    rr_ptr_d  = 1'b0;
                    rd_push_d = ~req1_we;
                    rd_id_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read-response pipeline; reset drops anything in flight.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            rd_v1_q    <= 1'b0;
            rd_id1_q   <= 1'b0;
            rd_v2_q    <= 1'b0;
            rd_id2_q   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rd_v1_q    <= rd_push_d;
            rd_id1_q   <= rd_id_d;
            rd_v2_q    <= rd_v1_q;
            rd_id2_q   <= rd_id1_q;
            rsp0_valid <= rd_v2_q && !rd_id2_q;
            rsp1_valid <= rd_v2_q &&  rd_id2_q;
            if (rd_v2_q && !rd_id2_q) begin
                rsp0_rdata <= sram_dout0;
            end
            if (rd_v2_q && rd_id2_q) begin
                rsp1_rdata <= sram_dout0;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: behavioural OpenRAM-style macro, golden
// memory, and a response scoreboard keyed by requester id, data and arrival edge.
module tb_sram_port_arbiter;

    logic       clk0  = 1'b0;
    logic       rstb0 = 1'b0;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [8:0] req0_addr  = '0;
    logic [7:0] req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [8:0] req1_addr  = '0;
    logic [7:0] req1_wdata = '0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       init_done;
    logic       sram_csb0, sram_web0;
    logic [8:0] sram_addr0;
    logic [7:0] sram_din0;
    logic [7:0] sram_dout0 = '0;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [40:0] exp_q[$];          // {id, data, edge index}
    logic [7:0]  gold [512];
    logic [7:0]  last0 = '0, last1 = '0;

    sram_port_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(9),
        .INIT_VALUE(8'h00)
    ) dut (
        .clk0(clk0), .rstb0(rstb0),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    // Macro model: pins captured at posedge, write/read performed at negedge.
    logic [7:0] mem [512];
    logic       m_csb = 1'b1, m_web = 1'b1;
    logic [8:0] m_addr = '0;
    logic [7:0] m_din  = '0;
    always @(posedge clk0) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end
    always @(negedge clk0) begin
        if (m_csb === 1'b0) begin
            if (m_web === 1'b0) mem[m_addr] <= m_din;
            else                sram_dout0  <= mem[m_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk0) begin
        logic [40:0] e;
        logic [40:0] got;
        if (rsp0_valid || rsp1_valid) begin
            check("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
            end else begin
                e   = exp_q.pop_front();
                got = rsp1_valid ? {1'b1, rsp1_rdata, cyc} : {1'b0, rsp0_rdata, cyc};
                check("rsp_id_data_edge", {23'd0, got}, {23'd0, e});
                if (rsp1_valid) begin
                    check("rsp0_hold", {56'd0, rsp0_rdata}, {56'd0, last0});
                    last1 = e[39:32];
                end else begin
                    check("rsp1_hold", {56'd0, rsp1_rdata}, {56'd0, last1});
                    last0 = e[39:32];
                end
            end
        end
    end

    task automatic accept(input logic id, input logic we, input logic [8:0] a, input logic [7:0] d);
        if (we) gold[a] = d;
        else    exp_q.push_back({id, gold[a], cyc + 32'd3});
    endtask

    task automatic cycle(input logic v0, input logic we0, input logic [8:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic [8:0] a1, input logic [7:0] d1,
                         output logic g0, output logic g1);
        @(negedge clk0);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #1;
        g0 = req0_ready;
        g1 = req1_ready;
        check("ready_onehot", {63'd0, g0 & g1}, 64'd0);
        if (v0 && g0) accept(1'b0, we0, a0, d0);
        if (v1 && g1) accept(1'b1, we1, a1, d1);
    endtask

    task automatic issue(input logic id, input logic we, input logic [8:0] a, input logic [7:0] d);
        logic g0, g1;
        if (id) cycle(1'b0, 1'b0, 9'd0, 8'd0, 1'b1, we, a, d, g0, g1);
        else    cycle(1'b1, we, a, d, 1'b0, 1'b0, 9'd0, 8'd0, g0, g1);
        check("sole_grant", {62'd0, g0, g1}, id ? 64'd1 : 64'd2);
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 9'd0, 8'd0, g0, g1);
    endtask

    task automatic sweep_check();
        for (int i = 0; i < 512; i++) begin
            @(negedge clk0);
            check("init_pins",
                  {40'd0, sram_csb0, sram_web0, sram_addr0, sram_din0, init_done, req0_ready, req1_ready},
                  {40'd0, 1'b0, 1'b0, 9'(i), 8'h00, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk0);
        check("init_end", {61'd0, sram_csb0, sram_web0, init_done}, 64'd7);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 512; i++) gold[i] = 8'h00;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk0);
        rstb0 = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        exp_q.delete();
        last0 = '0;
        last1 = '0;
        repeat (n) @(negedge clk0);
        check("reset_vals",
              {22'd0, sram_csb0, sram_web0, sram_addr0, sram_din0, req0_ready, req1_ready,
               rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata, init_done},
              {22'd0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0});
        rstb0 = 1'b1;
        sweep_check();
    endtask

    initial begin
        logic g0, g1;
        for (int i = 0; i < 512; i++) mem[i] = 8'hEE;

        // Power-up reset and initialisation sweep.
        do_reset(3);

        // Contention straight after reset: grants alternate starting with 0.
        // Also reads 0x000 and 0x1FF, which must hold the init value.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 9'h1FF, 8'h00, g0, g1);
            check("contention_grant", {62'd0, g0, g1}, (k % 2 == 0) ? 64'd2 : 64'd1);
        end
        idle(4);

        // Single requester write then read.
        issue(1'b0, 1'b1, 9'h123, 8'hA5);
        issue(1'b0, 1'b0, 9'h123, 8'h00);
        idle(4);

        // Preload then back-to-back reads from requester 1.
        issue(1'b0, 1'b1, 9'h010, 8'h10);
        issue(1'b0, 1'b1, 9'h011, 8'h11);
        issue(1'b0, 1'b1, 9'h012, 8'h12);
        issue(1'b1, 1'b0, 9'h010, 8'h00);
        issue(1'b1, 1'b0, 9'h011, 8'h00);
        issue(1'b1, 1'b0, 9'h012, 8'h00);
        idle(4);

        // Cross-requester coherence on consecutive edges.
        issue(1'b0, 1'b1, 9'h080, 8'h3C);
        issue(1'b1, 1'b0, 9'h080, 8'h00);
        idle(4);

        // Interleaved writes and reads with no bubble.
        issue(1'b1, 1'b1, 9'h0AA, 8'h5A);
        issue(1'b0, 1'b0, 9'h0AA, 8'h00);
        issue(1'b1, 1'b0, 9'h012, 8'h00);
        issue(1'b0, 1'b1, 9'h012, 8'hC3);
        issue(1'b0, 1'b0, 9'h012, 8'h00);
        idle(5);

        // Reset on the edge after a read accept: the response must never appear.
        issue(1'b0, 1'b0, 9'h123, 8'h00);
        do_reset(2);

        // Pointer restarts at 0; sweep has cleared the earlier writes.
        cycle(1'b1, 1'b0, 9'h123, 8'h00, 1'b1, 1'b0, 9'h080, 8'h00, g0, g1);
        check("post_reset_grant0", {62'd0, g0, g1}, 64'd2);
        cycle(1'b1, 1'b0, 9'h123, 8'h00, 1'b1, 1'b0, 9'h080, 8'h00, g0, g1);
        check("post_reset_grant1", {62'd0, g0, g1}, 64'd1);
        idle(6);

        check("responses_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester controller for the single RW port of the 512x8 OpenRAM SRAM macro. After reset it sequences a full-array initialisation sweep. It then arbitrates round-robin between two valid/ready requesters, drives registered commands onto the macro pins and returns read data with fixed latency on a per-requester response channel. It sits between the macro and its two client blocks; clients never touch macro pins directly.

## Interface
Parameters:
- DATA_WIDTH, 8, macro word width
- ADDR_WIDTH, 9, macro address width; RAM_DEPTH = 1 << ADDR_WIDTH
- INIT_VALUE, 8'h00, word written to every address during the init sweep

Ports:
- clk0  in  1  clock; same clock as the macro clk0
- rstb0  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  requester N has a command
- req0_ready / req1_ready  out  1  command accepted on an edge where valid && ready
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  word address
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data
- rsp0_valid / rsp1_valid  out  1  one-cycle read-data strobe
- rsp0_rdata / rsp1_rdata  out  DATA_WIDTH  read data; holds its value between strobes
- init_done  out  1  init sweep complete; stays high until the next reset
- sram_csb0  out  1  macro chip select, active low, registered
- sram_web0  out  1  macro write enable, active low, registered
- sram_addr0  out  ADDR_WIDTH  macro address, registered
- sram_din0  out  DATA_WIDTH  macro write data, registered
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- Reset (rstb0=0 at an edge) drives every output to its reset value:
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0
  - req*_ready=0, rsp*_valid=0, rsp*_rdata=0, init_done=0
  - state=INIT, init counter=0, round-robin pointer=0 (requester 0 favoured)
  - read pipeline emptied
- FSM has two states, INIT and RUN.
- INIT behaviour:
  - Each edge registers csb0=0, web0=0, addr0=counter, din0=INIT_VALUE, then increments the counter.
  - When the write to address RAM_DEPTH-1 has been registered, the next edge moves to RUN, sets init_done=1 and sets csb0=1, web0=1.
  - req*_ready=0 throughout INIT.
- RUN arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester the pointer favours gets ready=1, the other gets 0.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle.
- Accept (valid && ready at an edge):
  - Registers csb0=0, web0=~we, addr0=addr, din0=wdata.
  - Moves the pointer to favour the other requester.
- No accept at an edge: registers csb0=1, web0=1; addr0 and din0 hold their values.
- Reads push (valid, id) into a 2-stage pipeline.
  - Stage 2 samples sram_dout0 into rspN_rdata and pulses rspN_valid for the owning id.
  - The other requester's rdata is unchanged.
- Responses are in accept order and have no backpressure.
- Writes produce no response.
- Memory consistency: a write accepted at edge E is visible to a read accepted at E+1 or later, from either requester.

## Timing
- Accept at edge E, macro pins valid after E, macro captures at E+1:
  - Write: committed at the negedge after E+1.
  - Read: data sampled at E+2; rspN_valid is high in the cycle after E+2. Read latency is 2 edges.
- Sustained throughput is one command per cycle. Reads and writes may interleave back-to-back with no bubble.
- The init sweep occupies RAM_DEPTH cycles. init_done rises on edge RAM_DEPTH+1 after the first edge with rstb0=1. The first accept is possible on that same edge's following cycle.
- Reset mid-operation:
  - A command already on the macro pins at the reset edge is captured by the macro and completes.
  - Its read response, and any read in flight, is discarded: no rsp*_valid.
  - INIT restarts from address 0.
- Counter wrap: the counter stops at RAM_DEPTH-1 and never wraps into a second sweep.

## Test plan
- Reset then release: init sweep. Check csb0=0, web0=0 for exactly 512 consecutive cycles, addresses 0..511, din0=0x00; then init_done=1; reads of 0x000 and 0x1FF return 0x00.
- Single requester write/read: req0 writes 0xA5 to 0x123, then reads 0x123 on the next cycle. rsp0_valid pulses 2 edges after the read accept with rdata=0xA5; rsp1_valid stays 0.
- Contention: both requesters hold valid for 6 cycles. Grants alternate 0,1,0,1,0,1; exactly one ready per cycle; pointer restarts at 0 after reset.
- Back-to-back reads: req1 reads 0x010, 0x011, 0x012 (preloaded 0x10, 0x11, 0x12) on consecutive cycles. Three consecutive rsp1_valid pulses, data in order.
- Cross-requester coherence: req0 writes 0x3C to 0x080 at edge E; req1 reads 0x080 at E+1. rsp1_rdata=0x3C.
- Mid-operation reset: read accepted, rstb0=0 on the next edge. No rsp*_valid follows; outputs take reset values; after release the INIT sweep restarts at address 0.
